// File: rtl/instr_split_stage_pkg.sv
// ---------------------------------------------------------------------------
// instr_split_stage_pkg : field positions, opcodes and itype encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package instr_split_stage_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  typedef enum logic [1:0] {
    ITYPE_R = 2'd0,
    ITYPE_I = 2'd1,
    ITYPE_J = 2'd2
  } itype_e;

endpackage

`default_nettype wire

// File: rtl/instr_fields.sv
// ---------------------------------------------------------------------------
// instr_fields : splits a 32-bit instruction into fields; all zero when !i_valid
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_fields
  import instr_split_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_valid,
  input  logic [31:0]     i_instr,
  input  logic [31:0]     i_pc,
  output logic [5:0]      o_opcode,
  output logic [4:0]      o_rs,
  output logic [4:0]      o_rt,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_shamt,
  output logic [5:0]      o_funct,
  output logic [15:0]     o_imm16,
  output logic [25:0]     o_target,
  output logic [XLEN-1:0] o_imm_sext,
  output logic [XLEN-1:0] o_imm_zext,
  output logic [31:0]     o_jump_addr,
  output logic [1:0]      o_itype,
  output logic [31:0]     o_pc_out
);

  logic [5:0]  w_op;
  logic [15:0] w_imm;
  logic [3:0]  w_region;
  itype_e      w_itype;

  assign w_op  = i_instr[OPCODE_MSB:OPCODE_LSB];
  assign w_imm = i_instr[IMM_MSB:IMM_LSB];
  // Upper nibble of pc+4: a carry reaches bit 28 only when pc[27:2] is all ones.
  assign w_region = i_pc[31:28] + {3'b000, &i_pc[27:2]};

  always_comb begin
    case (w_op)
      OP_RTYPE:     w_itype = ITYPE_R;
      OP_J, OP_JAL: w_itype = ITYPE_J;
      default:      w_itype = ITYPE_I;
    endcase
  end

  always_comb begin
    o_opcode    = '0;
    o_rs        = '0;
    o_rt        = '0;
    o_rd        = '0;
    o_shamt     = '0;
    o_funct     = '0;
    o_imm16     = '0;
    o_target    = '0;
    o_imm_sext  = '0;
    o_imm_zext  = '0;
    o_jump_addr = '0;
    o_itype     = '0;
    o_pc_out    = '0;
    if (i_valid) begin
      o_opcode    = w_op;
      o_rs        = i_instr[RS_MSB:RS_LSB];
      o_rt        = i_instr[RT_MSB:RT_LSB];
      o_rd        = i_instr[RD_MSB:RD_LSB];
      o_shamt     = i_instr[SHAMT_MSB:SHAMT_LSB];
      o_funct     = i_instr[FUNCT_MSB:FUNCT_LSB];
      o_imm16     = w_imm;
      o_target    = i_instr[TARGET_MSB:TARGET_LSB];
      o_imm_sext  = XLEN'($signed(w_imm));
      o_imm_zext  = XLEN'(w_imm);
      o_jump_addr = {w_region, i_instr[TARGET_MSB:TARGET_LSB], 2'b00};
      o_itype     = w_itype;
      o_pc_out    = i_pc;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_split_stage.sv
// ---------------------------------------------------------------------------
// instr_split_stage : DEPTH-entry {instr,pc} FIFO with decoded head outputs.
// Optional INSTR_SPLIT_FLUSH_EN adds a flush input. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_split_stage
  import instr_split_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
`ifdef INSTR_SPLIT_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      funct,
  output logic [15:0]     imm16,
  output logic [25:0]     target,
  output logic [XLEN-1:0] imm_sext,
  output logic [XLEN-1:0] imm_zext,
  output logic [31:0]     jump_addr,
  output logic [1:0]      itype,
  output logic [31:0]     pc_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [31:0]      r_instr_mem [DEPTH];
  logic [31:0]      r_pc_mem    [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;
  logic w_clear;

`ifdef INSTR_SPLIT_FLUSH_EN
  assign w_clear = rst | flush;
`else
  assign w_clear = rst;
`endif

  // Ready depends only on the registered count, never on out_ready.
  assign in_ready  = (r_count < C_DEPTH);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= in_instr;
      r_pc_mem[r_wr_ptr]    <= in_pc;
    end
  end

  instr_fields #(
    .XLEN (XLEN)
  ) u_fields (
    .i_valid     (out_valid),
    .i_instr     (r_instr_mem[r_rd_ptr]),
    .i_pc        (r_pc_mem[r_rd_ptr]),
    .o_opcode    (opcode),
    .o_rs        (rs),
    .o_rt        (rt),
    .o_rd        (rd),
    .o_shamt     (shamt),
    .o_funct     (funct),
    .o_imm16     (imm16),
    .o_target    (target),
    .o_imm_sext  (imm_sext),
    .o_imm_zext  (imm_zext),
    .o_jump_addr (jump_addr),
    .o_itype     (itype),
    .o_pc_out    (pc_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_split_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_split_stage : self-checking bench for instr_split_stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_split_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [31:0]     in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      opcode;
  logic [4:0]      rs, rt, rd, shamt;
  logic [5:0]      funct;
  logic [15:0]     imm16;
  logic [25:0]     target;
  logic [XLEN-1:0] imm_sext, imm_zext;
  logic [31:0]     jump_addr;
  logic [1:0]      itype;
  logic [31:0]     pc_out;

  int checks   = 0;
  int failures = 0;

  // Reference queue of {instr, pc}, head at index 0.
  logic [63:0] mq[$];

  always #5 clk = ~clk;

  instr_split_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef INSTR_SPLIT_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .funct     (funct),
    .imm16     (imm16),
    .target    (target),
    .imm_sext  (imm_sext),
    .imm_zext  (imm_zext),
    .jump_addr (jump_addr),
    .itype     (itype),
    .pc_out    (pc_out)
  );

  // Advance one clock and apply the queue rules to the reference model.
  task automatic tick();
    bit push, pop, clr;
    push = in_valid && (mq.size() < DEPTH);
    pop  = (mq.size() != 0) && out_ready;
    clr  = rst;
`ifdef INSTR_SPLIT_FLUSH_EN
    clr  = clr || flush;
`endif
    @(posedge clk);
    if (clr) mq.delete();
    else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({in_instr, in_pc});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_instr = '0; in_pc = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if ({opcode, pc_out, jump_addr, imm_sext} !== '0) begin failures++; $display("FAIL reset_data got op=%h pc=%h ja=%h sx=%h exp=0", opcode, pc_out, jump_addr, imm_sext); end
  endtask

  task automatic push_one(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_rtype();
    push_one(32'h012A_4020, 32'h0000_1000);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rtype_valid got=%0b exp=1", out_valid); end
    checks++; if ({opcode, rs, rt, rd, shamt, funct} !== {6'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20})
      begin failures++; $display("FAIL rtype_fields got op=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h exp 0/9/10/8/0/20", opcode, rs, rt, rd, shamt, funct); end
    checks++; if (itype !== 2'd0) begin failures++; $display("FAIL rtype_itype got=%0d exp=0", itype); end
    drain();
  endtask

  task automatic test_itype();
    push_one(32'h8FA8_FFFC, 32'h0000_2000);
    checks++; if ({opcode, rs, rt} !== {6'h23, 5'd29, 5'd8})
      begin failures++; $display("FAIL itype_fields got op=%h rs=%0d rt=%0d exp 23/29/8", opcode, rs, rt); end
    checks++; if (imm_sext !== 32'hFFFF_FFFC) begin failures++; $display("FAIL itype_sext got=%h exp=fffffffc", imm_sext); end
    checks++; if (imm_zext !== 32'h0000_FFFC) begin failures++; $display("FAIL itype_zext got=%h exp=0000fffc", imm_zext); end
    checks++; if (itype !== 2'd1) begin failures++; $display("FAIL itype_itype got=%0d exp=1", itype); end
    drain();
  endtask

  task automatic test_jtype();
    push_one(32'h0810_0000, 32'h0040_0000);
    checks++; if (itype !== 2'd2) begin failures++; $display("FAIL jtype_itype got=%0d exp=2", itype); end
    checks++; if (target !== 26'h010_0000) begin failures++; $display("FAIL jtype_target got=%h exp=0100000", target); end
    checks++; if (jump_addr !== 32'h0040_0000) begin failures++; $display("FAIL jtype_jump got=%h exp=00400000", jump_addr); end
    checks++; if (pc_out !== 32'h0040_0000) begin failures++; $display("FAIL jtype_pc got=%h exp=00400000", pc_out); end
    drain();
    // pc+4 carries into the region nibble
    push_one(32'h0C00_0001, 32'h1FFF_FFFC);
    checks++; if (jump_addr !== 32'h2000_0004) begin failures++; $display("FAIL jtype_carry got=%h exp=20000004", jump_addr); end
    drain();
  endtask

  task automatic test_full_order();
    logic [31:0] pcs[$];
    int rd_idx = 0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_instr = $urandom; in_pc = 32'h100 + 32'(i) * 4;
      pcs.push_back(in_pc);
      tick();
      checks++; if (in_ready !== (i + 1 < DEPTH)) begin failures++; $display("FAIL fill_ready i=%0d got=%0b exp=%0b", i, in_ready, (i + 1 < DEPTH)); end
    end
    // full with a concurrent pop: the offered entry must be refused
    in_instr = $urandom; in_pc = 32'hDEAD_0000; out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_pop_ready got=%0b exp=0", in_ready); end
    checks++; if (pc_out !== pcs[rd_idx]) begin failures++; $display("FAIL order_head got=%h exp=%h", pc_out, pcs[rd_idx]); end
    tick(); rd_idx++;
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      in_valid = 1'b1; in_instr = $urandom; in_pc = 32'h200 + 32'(i) * 4;
      checks++; if (pc_out !== pcs[rd_idx] || out_valid !== 1'b1 || in_ready !== 1'b1)
        begin failures++; $display("FAIL wrap_order i=%0d got pc=%h v=%0b r=%0b exp pc=%h v=1 r=1", i, pc_out, out_valid, in_ready, pcs[rd_idx]); end
      pcs.push_back(in_pc);
      tick(); rd_idx++;
    end
    in_valid = 1'b0;
    while (rd_idx < pcs.size()) begin
      checks++; if (pc_out !== pcs[rd_idx]) begin failures++; $display("FAIL drain_order got=%h exp=%h", pc_out, pcs[rd_idx]); end
      tick(); rd_idx++;
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drained_valid got=%0b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_clear_full(input bit use_flush);
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_instr = 32'h8FA8_FFFC; in_pc = 32'h300 + 32'(i) * 4;
      tick();
    end
    if (use_flush) flush = 1'b1; else rst = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL clear_ctrl flush=%0b got v=%0b r=%0b exp v=0 r=1", use_flush, out_valid, in_ready); end
    checks++; if ({opcode, rs, rt, rd, shamt, funct, imm16, target, imm_sext, imm_zext, jump_addr, itype, pc_out} !== '0)
      begin failures++; $display("FAIL clear_data flush=%0b got op=%h imm=%h pc=%h exp all 0", use_flush, opcode, imm16, pc_out); end
  endtask

  task automatic test_random();
    logic [31:0] ei, ep, e_sx, e_ja;
    logic [5:0]  e_op;
    logic [15:0] e_imm;
    logic [1:0]  e_it;
    for (int n = 0; n < 400; n++) begin
      if (mq.size() != 0) {ei, ep} = mq[0]; else begin ei = '0; ep = '0; end
      e_op  = 6'(ei >> 26);
      e_imm = 16'(ei % 65536);
      e_sx  = (e_imm >= 16'h8000) ? 32'(e_imm) + 32'hFFFF_0000 : 32'(e_imm);
      e_ja  = ((ep + 32'd4) & 32'hF000_0000) | ((ei % 32'h0400_0000) * 4);
      e_it  = (e_op == 0) ? 2'd0 : ((e_op == 2 || e_op == 3) ? 2'd2 : 2'd1);
      checks++; if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < DEPTH))
        begin failures++; $display("FAIL rnd_ctrl n=%0d got v=%0b r=%0b exp size=%0d", n, out_valid, in_ready, mq.size()); end
      checks++; if (opcode !== e_op || rs !== 5'((ei >> 21) % 32) || rt !== 5'((ei >> 16) % 32) || rd !== 5'((ei >> 11) % 32))
        begin failures++; $display("FAIL rnd_regs n=%0d got op=%h rs=%0d rt=%0d rd=%0d instr=%h", n, opcode, rs, rt, rd, ei); end
      checks++; if (shamt !== 5'((ei >> 6) % 32) || funct !== 6'(ei % 64) || imm16 !== e_imm || target !== 26'(ei % 32'h0400_0000))
        begin failures++; $display("FAIL rnd_fields n=%0d got sh=%0d fn=%h imm=%h tg=%h instr=%h", n, shamt, funct, imm16, target, ei); end
      checks++; if (imm_sext !== e_sx || imm_zext !== 32'(e_imm))
        begin failures++; $display("FAIL rnd_ext n=%0d got sx=%h zx=%h exp sx=%h zx=%h", n, imm_sext, imm_zext, e_sx, 32'(e_imm)); end
      checks++; if (jump_addr !== e_ja || itype !== e_it || pc_out !== ep)
        begin failures++; $display("FAIL rnd_jump n=%0d got ja=%h it=%0d pc=%h exp ja=%h it=%0d pc=%h", n, jump_addr, itype, pc_out, e_ja, e_it, ep); end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_instr  = $urandom;
      case ($urandom_range(0, 4))
        0: in_instr[31:26] = 6'h00;
        1: in_instr[31:26] = 6'h02;
        2: in_instr[31:26] = 6'h03;
        default: ;
      endcase
      in_pc = ($urandom_range(0, 3) == 0) ? {4'($urandom), 26'h3FF_FFFF, 2'($urandom)} : $urandom;
      rst = ($urandom_range(0, 60) == 0);
      tick();
      rst = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_jtype();
    test_full_order();
    test_clear_full(1'b0);
`ifdef INSTR_SPLIT_FLUSH_EN
    test_clear_full(1'b1);
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_split_stage.md
INSTR_SPLIT_STAGE -- requirements
Module: instr_split_stage

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the width of the extended-immediate output (legal values >= 16).
REQ-002 Parameter DEPTH, default 2, SHALL set queue entries (legal values: power of 2, >= 2).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL qualify in_instr and in_pc.
REQ-006 in_ready  output  1  SHALL indicate the stage accepts an entry this cycle.
REQ-007 in_instr  input  32  SHALL carry the raw instruction word.
REQ-008 in_pc  input  32  SHALL carry the instruction's address.
REQ-009 out_valid  output  1  SHALL indicate the head entry is presented.
REQ-010 out_ready  input  1  SHALL indicate the consumer takes the head entry this cycle.
REQ-011 Field outputs opcode[5:0], rs[4:0], rt[4:0], rd[4:0], shamt[4:0], funct[5:0], imm16[15:0], target[25:0] SHALL present head-entry bits [31:26], [25:21], [20:16], [15:11], [10:6], [5:0], [15:0], [25:0].
REQ-012 imm_sext[XLEN-1:0] and imm_zext[XLEN-1:0] outputs SHALL present imm16 sign- and zero-extended to XLEN.
REQ-013 jump_addr[31:0] output SHALL equal {pc_plus4[31:28], target, 2'b00}, where pc_plus4 = head pc + 4, modulo 2^32.
REQ-014 itype[1:0] output SHALL encode 0 = R (opcode 0), 2 = J (opcode 2 or 3), 1 = I (any other opcode).
REQ-015 pc_out[31:0] output SHALL present the head entry's pc.

Function
REQ-016 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-017 in_ready SHALL equal (count < DEPTH), with no combinational path from out_ready.
REQ-018 out_valid SHALL equal (count != 0).
REQ-019 The queue SHALL be FIFO-ordered, storing {instr, pc} per entry, with read/write pointers wrapping modulo DEPTH.
REQ-020 Latency SHALL be one cycle: an entry pushed in cycle N is first presented in cycle N+1, with no same-cycle bypass.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 When full, in_ready SHALL be 0 even if a pop occurs in the same cycle.
REQ-023 When out_valid = 0, every data output (REQ-011..015) SHALL be driven to 0.
REQ-024 All data outputs SHALL be combinational decodes of the registered head entry, holding stable while out_valid && !out_ready.

Reset
REQ-025 On rst = 1 at a clock edge, count and both pointers SHALL clear to 0; consequently in_ready = 1, out_valid = 0 and all data outputs = 0 in the following cycle.
REQ-026 Reset SHALL override a simultaneous push or pop, and SHALL discard entries held mid-operation; storage contents need not be cleared.

Configuration
REQ-027 With macro INSTR_SPLIT_FLUSH_EN defined, a 1-bit input flush SHALL exist; flush = 1 at a clock edge SHALL empty the queue exactly as reset does, overriding any same-cycle push or pop.
REQ-028 Without INSTR_SPLIT_FLUSH_EN, the flush port SHALL be absent and the queue SHALL empty only on rst.

Structure
REQ-029 A shared package SHALL hold the field bit-position constants, the opcode constants OP_RTYPE = 6'h00, OP_J = 6'h02 and OP_JAL = 6'h03, and the itype encoding typedef.
REQ-030 The field split and extension logic SHALL be one sub-module, instr_fields, instantiated on the head entry; the queue control SHALL stay in instr_split_stage.

Verification
REQ-031 Reset, then push 0x012A4020: the next cycle shows out_valid = 1, opcode = 0, rs = 9, rt = 10, rd = 8, shamt = 0, funct = 0x20, itype = 0.
REQ-032 Push 0x8FA8FFFC: opcode = 0x23, rs = 29, rt = 8, imm_sext = 0xFFFFFFFC, imm_zext = 0x0000FFFC, itype = 1.
REQ-033 Push 0x08100000 with pc = 0x00400000: itype = 2, target = 0x0100000, jump_addr = 0x00400000.
REQ-034 Hold out_ready = 0 and push DEPTH entries: in_ready drops after the DEPTH-th push; releasing out_ready pops in push order, and pops with simultaneous pushes keep count constant across pointer wrap.
REQ-035 Fill the queue, then assert rst (and flush when INSTR_SPLIT_FLUSH_EN is defined) together with in_valid: the next cycle shows out_valid = 0, in_ready = 1 and all data outputs = 0.
